// File: rtl/spi_master_tx_if.sv
// Handshake and SPI pin bundle for spi_master_tx.
// The slave modport is the transmitter's side; master is the upstream/driver side.
interface spi_master_tx_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              busy;
  logic              done;
  logic              spi_sck;
  logic              spi_cs;
  logic              spi_mosi;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, done, spi_sck, spi_cs, spi_mosi
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, done, spi_sck, spi_cs, spi_mosi
  );
endinterface

// File: rtl/spi_master_tx.sv
// SPI mode-0 master transmitter: one DATA_W word per frame, MSB first, with
// every SPI phase (setup, SCK high/low, hold, CS-high gap) lasting CLK_DIV cycles.
module spi_master_tx #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned DATA_W  = 8
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  spi_master_tx_if.slave bus
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SCK_HI,
    SCK_LO,
    HOLD,
    GAP
  } state_e;

  state_e            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              sck_q, sck_d;
  logic              cs_q, cs_d;
  logic              mosi_q, mosi_d;
  logic              done_q, done_d;

  logic              div_end;
  logic [DATA_W-1:0] shift_nxt;

  always_comb begin
    div_end   = (div_q == DIV_W'(CLK_DIV - 1));
    shift_nxt = shift_q << 1;

    state_d = state_q;
    div_d   = div_end ? '0 : div_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    sck_d   = sck_q;
    cs_d    = cs_q;
    mosi_d  = mosi_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        div_d = '0;
        bit_d = '0;
        // tx_ready is exactly "in IDLE", so tx_valid alone completes the handshake
        if (bus.tx_valid) begin
          state_d = SETUP;
          shift_d = bus.tx_data;
          cs_d    = 1'b0;
          mosi_d  = bus.tx_data[DATA_W-1];
        end
      end
      SETUP: begin
        if (div_end) begin
          state_d = SCK_HI;
          sck_d   = 1'b1;
        end
      end
      SCK_HI: begin
        if (div_end) begin
          sck_d = 1'b0;
          if (bit_q == BIT_W'(DATA_W - 1)) begin
            state_d = HOLD;
          end else begin
            // next bit launches on the falling edge, a full half-period before the next rise
            state_d = SCK_LO;
            shift_d = shift_nxt;
            mosi_d  = shift_nxt[DATA_W-1];
            bit_d   = bit_q + 1'b1;
          end
        end
      end
      SCK_LO: begin
        if (div_end) begin
          state_d = SCK_HI;
          sck_d   = 1'b1;
        end
      end
      HOLD: begin
        if (div_end) begin
          state_d = GAP;
          cs_d    = 1'b1;
          done_d  = 1'b1;
          mosi_d  = 1'b0;
        end
      end
      GAP: begin
        if (div_end) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      sck_q   <= 1'b0;
      cs_q    <= 1'b1;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      sck_q   <= sck_d;
      cs_q    <= cs_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
    end
  end

  assign bus.tx_ready = (state_q == IDLE);
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.spi_sck  = sck_q;
  assign bus.spi_cs   = cs_q;
  assign bus.spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_master_tx.sv
// Directed bench for spi_master_tx: an 8-bit/div-4 instance and a 12-bit/div-7 instance,
// observed by a receiver-like monitor that samples the SPI pins on the falling sys_clk edge.
module tb_spi_master_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  spi_master_tx_if #(.DATA_W(8))  bus_a ();
  spi_master_tx_if #(.DATA_W(12)) bus_b ();

  spi_master_tx #(.CLK_DIV(4), .DATA_W(8)) dut_a (
    .sys_clk (clk),
    .sys_rst (rst),
    .bus     (bus_a.slave)
  );

  spi_master_tx #(.CLK_DIV(7), .DATA_W(12)) dut_b (
    .sys_clk (clk),
    .sys_rst (rst),
    .bus     (bus_b.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor A: relative cycle = cycles since the handshake edge (handshake edge = 0)
  int          hs_ref_a = 0, hs_cnt_a = 0, rise_cnt_a = 0, done_cnt_a = 0, done_rel_a = 0;
  int          cs_low_a = 0, ready_rel_a = 0, viol_a = 0, latch_cnt_a = 0;
  int          rise_rel_a [256];
  logic [31:0] rx_a = '0;
  logic [31:0] latched_a [16];
  logic        psck_a = 1'b0, pcs_a = 1'b1, pmosi_a = 1'b0, pready_a = 1'b1;

  always @(negedge clk) begin
    if (!psck_a && bus_a.spi_sck) begin
      rise_rel_a[rise_cnt_a % 256] <= cyc - hs_ref_a;
      rise_cnt_a <= rise_cnt_a + 1;
      rx_a       <= {rx_a[30:0], bus_a.spi_mosi};
      if (bus_a.spi_mosi !== pmosi_a) viol_a <= viol_a + 1;
    end
    if (psck_a && bus_a.spi_sck && (bus_a.spi_mosi !== pmosi_a)) viol_a <= viol_a + 1;
    if (!pcs_a && bus_a.spi_cs) begin
      latched_a[latch_cnt_a % 16] <= rx_a;
      latch_cnt_a <= latch_cnt_a + 1;
    end
    if (bus_a.done) begin
      done_cnt_a <= done_cnt_a + 1;
      done_rel_a <= cyc - hs_ref_a;
    end
    if (!bus_a.spi_cs) cs_low_a <= cs_low_a + 1;
    if (!pready_a && bus_a.tx_ready) ready_rel_a <= cyc - hs_ref_a;
    if (bus_a.tx_valid && bus_a.tx_ready) begin
      hs_cnt_a <= hs_cnt_a + 1;
      hs_ref_a <= cyc;
    end
    psck_a   <= bus_a.spi_sck;
    pcs_a    <= bus_a.spi_cs;
    pmosi_a  <= bus_a.spi_mosi;
    pready_a <= bus_a.tx_ready;
  end

  // Monitor B: same scheme for the 12-bit instance
  int          hs_ref_b = 0, rise_cnt_b = 0, done_cnt_b = 0, done_rel_b = 0, ready_rel_b = 0;
  int          rise_rel_b [256];
  logic [31:0] rx_b = '0;
  logic        psck_b = 1'b0, pready_b = 1'b1;

  always @(negedge clk) begin
    if (!psck_b && bus_b.spi_sck) begin
      rise_rel_b[rise_cnt_b % 256] <= cyc - hs_ref_b;
      rise_cnt_b <= rise_cnt_b + 1;
      rx_b       <= {rx_b[30:0], bus_b.spi_mosi};
    end
    if (bus_b.done) begin
      done_cnt_b <= done_cnt_b + 1;
      done_rel_b <= cyc - hs_ref_b;
    end
    if (!pready_b && bus_b.tx_ready) ready_rel_b <= cyc - hs_ref_b;
    if (bus_b.tx_valid && bus_b.tx_ready) hs_ref_b <= cyc;
    psck_b   <= bus_b.spi_sck;
    pready_b <= bus_b.tx_ready;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) until tx_ready is high, then let the monitor take its sample.
  task automatic wait_ready_a(input bit noisy);
    int n = 0;
    while (!bus_a.tx_ready && n < 200) begin
      if (noisy) begin
        bus_a.tx_data  = 8'($urandom);
        bus_a.tx_valid = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      n++;
    end
    bus_a.tx_valid = 1'b0;
    chk("ready_within_bound", {31'd0, bus_a.tx_ready}, 32'd1);
    @(negedge clk); #1;
  endtask

  // One complete frame on instance A; checks the first post-handshake cycle.
  task automatic run_frame_a(input logic [7:0] d, input bit noisy);
    @(posedge clk); #1;
    bus_a.tx_data  = d;
    bus_a.tx_valid = 1'b1;
    @(posedge clk); #1;
    chk($sformatf("c1_cs_%0h", d),    {31'd0, bus_a.spi_cs},   32'd0);
    chk($sformatf("c1_mosi_%0h", d),  {31'd0, bus_a.spi_mosi}, {31'd0, d[7]});
    chk($sformatf("c1_ready_%0h", d), {31'd0, bus_a.tx_ready}, 32'd0);
    chk($sformatf("c1_busy_%0h", d),  {31'd0, bus_a.busy},     32'd1);
    bus_a.tx_valid = 1'b0;
    bus_a.tx_data  = 8'($urandom);
    wait_ready_a(noisy);
  endtask

  int r0, d0, h0, c0, v0, l0, h1, n;

  initial begin
    bus_a.tx_valid = 1'b0;
    bus_a.tx_data  = '0;
    bus_b.tx_valid = 1'b0;
    bus_b.tx_data  = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs",    {31'd0, bus_a.spi_cs},   32'd1);
    chk("rst_sck",   {31'd0, bus_a.spi_sck},  32'd0);
    chk("rst_mosi",  {31'd0, bus_a.spi_mosi}, 32'd0);
    chk("rst_done",  {31'd0, bus_a.done},     32'd0);
    chk("rst_ready", {31'd0, bus_a.tx_ready}, 32'd1);
    chk("rst_busy",  {31'd0, bus_a.busy},     32'd0);
    #3 rst = 1'b0;
    repeat (2) @(posedge clk);

    // Single frame 0xA5 with full timing
    r0 = rise_cnt_a; d0 = done_cnt_a; c0 = cs_low_a; v0 = viol_a;
    run_frame_a(8'hA5, 1'b0);
    chk("a5_rises", rise_cnt_a - r0, 8);
    chk("a5_data", rx_a[7:0], 32'hA5);
    for (int i = 0; i < 8; i++)
      chk($sformatf("a5_rise%0d_cycle", i), rise_rel_a[(r0 + i) % 256], 8 * i + 5);
    chk("a5_cs_low_cycles", cs_low_a - c0, 68);
    chk("a5_done_count", done_cnt_a - d0, 1);
    chk("a5_done_cycle", done_rel_a, 69);
    chk("a5_ready_cycle", ready_rel_a, 73);
    chk("a5_mosi_stable", viol_a - v0, 0);

    // Back-to-back 0x3C, 0xC3 with tx_valid held high
    h0 = hs_cnt_a; d0 = done_cnt_a; l0 = latch_cnt_a;
    @(posedge clk); #1;
    bus_a.tx_data  = 8'h3C;
    bus_a.tx_valid = 1'b1;
    @(posedge clk); #1;
    h1 = hs_ref_a;
    bus_a.tx_data = 8'hC3;
    n = 0;
    while (hs_cnt_a != h0 + 2 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    bus_a.tx_valid = 1'b0;
    chk("b2b_handshakes", hs_cnt_a - h0, 2);
    chk("b2b_second_hs_cycle", hs_ref_a - h1, 73);
    wait_ready_a(1'b0);
    chk("b2b_word0", latched_a[l0 % 16] & 32'hFF, 32'h3C);
    chk("b2b_word1", latched_a[(l0 + 1) % 16] & 32'hFF, 32'hC3);
    chk("b2b_done_count", done_cnt_a - d0, 2);

    // Boundary words
    r0 = rise_cnt_a; v0 = viol_a;
    run_frame_a(8'h00, 1'b0);
    chk("x00_rises", rise_cnt_a - r0, 8);
    chk("x00_data", rx_a[7:0], 32'h00);
    r0 = rise_cnt_a;
    run_frame_a(8'hFF, 1'b0);
    chk("xff_rises", rise_cnt_a - r0, 8);
    chk("xff_data", rx_a[7:0], 32'hFF);
    chk("bound_mosi_stable", viol_a - v0, 0);

    // Input noise during a frame of 0x81
    r0 = rise_cnt_a; h0 = hs_cnt_a;
    run_frame_a(8'h81, 1'b1);
    chk("noise_data", rx_a[7:0], 32'h81);
    chk("noise_rises", rise_cnt_a - r0, 8);
    chk("noise_handshakes", hs_cnt_a - h0, 1);

    // Asynchronous reset at cycle 30 of a 0xFF frame
    d0 = done_cnt_a;
    @(posedge clk); #1;
    bus_a.tx_data  = 8'hFF;
    bus_a.tx_valid = 1'b1;
    @(posedge clk); #1;
    bus_a.tx_valid = 1'b0;
    repeat (29) @(posedge clk);
    #3;
    chk("pre_rst_sck", {31'd0, bus_a.spi_sck}, 32'd1);
    chk("pre_rst_cs",  {31'd0, bus_a.spi_cs},  32'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_cs",    {31'd0, bus_a.spi_cs},   32'd1);
    chk("mid_rst_sck",   {31'd0, bus_a.spi_sck},  32'd0);
    chk("mid_rst_mosi",  {31'd0, bus_a.spi_mosi}, 32'd0);
    chk("mid_rst_ready", {31'd0, bus_a.tx_ready}, 32'd1);
    chk("mid_rst_busy",  {31'd0, bus_a.busy},     32'd0);
    @(posedge clk); #3;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_no_done", done_cnt_a - d0, 0);
    r0 = rise_cnt_a;
    run_frame_a(8'h5A, 1'b0);
    chk("post_rst_data", rx_a[7:0], 32'h5A);
    chk("post_rst_rises", rise_cnt_a - r0, 8);
    chk("post_rst_done", done_cnt_a - d0, 1);

    // CLK_DIV=7, DATA_W=12 instance
    r0 = rise_cnt_b; d0 = done_cnt_b;
    @(posedge clk); #1;
    bus_b.tx_data  = 12'h9F3;
    bus_b.tx_valid = 1'b1;
    @(posedge clk); #1;
    bus_b.tx_valid = 1'b0;
    n = 0;
    while (!bus_b.tx_ready && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    @(negedge clk); #1;
    chk("w12_ready_within_bound", {31'd0, bus_b.tx_ready}, 32'd1);
    chk("w12_rises", rise_cnt_b - r0, 12);
    chk("w12_data", rx_b[11:0], 32'h9F3);
    chk("w12_first_rise", rise_rel_b[r0 % 256], 8);
    chk("w12_last_rise", rise_rel_b[(r0 + 11) % 256], 8 + 11 * 14);
    chk("w12_done_count", done_cnt_b - d0, 1);
    chk("w12_done_cycle", done_rel_b, 176);
    chk("w12_ready_cycle", ready_rel_b, 183);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
